// File: rtl/uart_mmio_fifo.sv
// ============================================================================
// Module   : uart_mmio_fifo
// Purpose  : MMIO UART buffer with TX/RX FIFOs plus cycle/instret counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_mmio_fifo #(
    parameter int          DEPTH = 8,
    parameter logic [31:0] BASE  = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] wdata,
    input  logic        inst_retire,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [4:0]  OFF_CTRL = 5'h00;
    localparam logic [4:0]  OFF_RXD  = 5'h04;
    localparam logic [4:0]  OFF_TXD  = 5'h08;
    localparam logic [4:0]  OFF_CYC  = 5'h10;
    localparam logic [4:0]  OFF_INS  = 5'h14;
    localparam logic [4:0]  OFF_RST  = 5'h18;
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    logic [7:0]  tx_mem_q [DEPTH];
    logic [7:0]  rx_mem_q [DEPTH];
    logic [AW:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [AW:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic        tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
    logic [31:0] cycle_q, cycle_d, instret_q, instret_d;
    logic [31:0] rdata_q, rdata_d;

    logic w_in_win, w_sel_ctrl, w_sel_rxd, w_sel_txd, w_sel_cyc, w_sel_ins, w_sel_rst;
    logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic w_tx_wr, w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_cnt_rst;
    logic w_unused;

    assign w_unused   = &{1'b0, wdata[31:8]};

    assign w_in_win   = (addr[31:5] == BASE[31:5]);
    assign w_sel_ctrl = w_in_win && (addr[4:0] == OFF_CTRL);
    assign w_sel_rxd  = w_in_win && (addr[4:0] == OFF_RXD);
    assign w_sel_txd  = w_in_win && (addr[4:0] == OFF_TXD);
    assign w_sel_cyc  = w_in_win && (addr[4:0] == OFF_CYC);
    assign w_sel_ins  = w_in_win && (addr[4:0] == OFF_INS);
    assign w_sel_rst  = w_in_win && (addr[4:0] == OFF_RST);

    assign w_tx_empty = (tx_wptr_q == tx_rptr_q);
    assign w_tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                        (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
    assign w_rx_empty = (rx_wptr_q == rx_rptr_q);
    assign w_rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                        (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);

    // A store into a full TX FIFO still lands if the transmitter drains the head this cycle.
    assign w_tx_pop   = !w_tx_empty && tx_ready;
    assign w_tx_wr    = wr_en && w_sel_txd;
    assign w_tx_push  = w_tx_wr && (!w_tx_full || w_tx_pop);
    assign w_rx_push  = rx_valid && !w_rx_full;
    assign w_rx_pop   = rd_en && w_sel_rxd && !w_rx_empty;
    assign w_cnt_rst  = wr_en && w_sel_rst;

    assign tx_valid   = !w_tx_empty;
    assign tx_data    = w_tx_empty ? 8'h00 : tx_mem_q[tx_rptr_q[AW-1:0]];
    assign rx_ready   = !w_rx_full;
    assign rdata      = rdata_q;

    always_comb begin
        tx_wptr_d = w_tx_push ? tx_wptr_q + PTR_ONE : tx_wptr_q;
        tx_rptr_d = w_tx_pop  ? tx_rptr_q + PTR_ONE : tx_rptr_q;
        rx_wptr_d = w_rx_push ? rx_wptr_q + PTR_ONE : rx_wptr_q;
        rx_rptr_d = w_rx_pop  ? rx_rptr_q + PTR_ONE : rx_rptr_q;

        tx_ovf_d  = tx_ovf_q | (w_tx_wr && w_tx_full && !w_tx_pop);
        rx_ovf_d  = rx_ovf_q | (rx_valid && w_rx_full && !w_rx_pop);
        cycle_d   = cycle_q + 32'd1;
        instret_d = instret_q + {31'd0, inst_retire};
        if (w_cnt_rst) begin
            tx_ovf_d  = 1'b0;
            rx_ovf_d  = 1'b0;
            cycle_d   = 32'd0;
            instret_d = 32'd0;
        end

        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = 32'd0;
            if (w_sel_ctrl)
                rdata_d = {28'd0, rx_ovf_q, tx_ovf_q, !w_rx_empty, !w_tx_full};
            else if (w_sel_rxd && !w_rx_empty)
                rdata_d = {24'd0, rx_mem_q[rx_rptr_q[AW-1:0]]};
            else if (w_sel_cyc)
                rdata_d = cycle_q;
            else if (w_sel_ins)
                rdata_d = instret_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            tx_ovf_q  <= 1'b0;
            rx_ovf_q  <= 1'b0;
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
            rdata_q   <= 32'd0;
        end else begin
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_ovf_q  <= rx_ovf_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            rdata_q   <= rdata_d;
        end
    end

    // Storage is left uninitialised; reset only empties the FIFOs via the pointers.
    always_ff @(posedge clk) begin
        if (!rst && w_tx_push)
            tx_mem_q[tx_wptr_q[AW-1:0]] <= wdata[7:0];
        if (!rst && w_rx_push)
            rx_mem_q[rx_wptr_q[AW-1:0]] <= rx_data;
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_mmio_fifo.sv
// ============================================================================
// Module   : tb_uart_mmio_fifo
// Purpose  : Directed self-checking bench for uart_mmio_fifo.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_mmio_fifo;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] wdata = '0;
    logic        inst_retire = 1'b0;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    int n_checks = 0;
    int n_fail   = 0;

    uart_mmio_fifo #(.DEPTH(8), .BASE(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .wdata      (wdata),
        .inst_retire(inst_retire),
        .rdata      (rdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_read_check(input logic [4:0] off, input logic [31:0] exp, input string tag);
        addr  = BASE + {27'd0, off};
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        addr  = '0;
        check_eq(tag, rdata, exp);
    endtask

    task automatic cpu_write(input logic [4:0] off, input logic [31:0] data);
        addr  = BASE + {27'd0, off};
        wdata = data;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        addr  = '0;
    endtask

    initial begin
        // Reset and idle behaviour
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_rdata",    rdata,              32'h0);
        check_eq("rst_tx_valid", {31'd0, tx_valid},  32'h0);
        check_eq("rst_tx_data",  {24'd0, tx_data},   32'h0);
        check_eq("rst_rx_ready", {31'd0, rx_ready},  32'h1);
        cpu_read_check(5'h00, 32'h1, "ctrl_after_rst");
        repeat (10) tick();
        cpu_read_check(5'h10, 32'd11, "cycle_idle");
        repeat (3) tick();
        check_eq("rdata_hold", rdata, 32'd11);
        cpu_read_check(5'h08, 32'h0, "read_txdata_wo");

        // TX overflow with transmitter stalled, then drain
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++)
            cpu_write(5'h08, 32'h41 + i);
        check_eq("tx_head_41", {23'd0, tx_valid, tx_data}, 32'h141);
        cpu_read_check(5'h00, 32'h4, "ctrl_tx_ovf");
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("tx_drain1", {23'd0, tx_valid, tx_data}, 32'h141 + i);
            tick();
        end
        check_eq("tx_empty1", {31'd0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // Push into a full TX FIFO while it drains
        cpu_write(5'h18, 32'hDEAD_BEEF);
        for (int i = 0; i < 8; i++)
            cpu_write(5'h08, 32'h61 + i);
        cpu_read_check(5'h00, 32'h0, "ctrl_tx_full");
        addr     = BASE + 32'h8;
        wdata    = 32'h55;
        wr_en    = 1'b1;
        tx_ready = 1'b1;
        tick();
        wr_en    = 1'b0;
        tx_ready = 1'b0;
        addr     = '0;
        cpu_read_check(5'h00, 32'h0, "ctrl_full_pushpop");
        tx_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check_eq("tx_drain2", {23'd0, tx_valid, tx_data}, 32'h162 + i);
            tick();
        end
        check_eq("tx_last_55", {23'd0, tx_valid, tx_data}, 32'h155);
        tick();
        check_eq("tx_empty2", {31'd0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // RX push and CPU reads including the empty read
        rx_valid = 1'b1;
        rx_data  = 8'h10; tick();
        rx_data  = 8'h20; tick();
        rx_data  = 8'h30; tick();
        rx_valid = 1'b0;
        cpu_read_check(5'h04, 32'h10, "rxd_0");
        cpu_read_check(5'h04, 32'h20, "rxd_1");
        cpu_read_check(5'h04, 32'h30, "rxd_2");
        cpu_read_check(5'h04, 32'h00, "rxd_empty");
        cpu_read_check(5'h00, 32'h1, "ctrl_rx_drained");

        // RX overflow, then RST write in the same cycle rx_valid is still high
        for (int i = 0; i < 8; i++) begin
            rx_data  = 8'h80 + i[7:0];
            rx_valid = 1'b1;
            tick();
        end
        check_eq("rx_ready_full", {31'd0, rx_ready}, 32'h0);
        tick();
        cpu_read_check(5'h00, 32'hB, "ctrl_rx_ovf");
        cpu_write(5'h18, 32'h0);
        rx_valid = 1'b0;
        cpu_read_check(5'h00, 32'h3, "ctrl_after_rstw");
        cpu_read_check(5'h10, 32'd1, "cycle_after_rstw");
        cpu_read_check(5'h14, 32'd0, "instret_after_rstw");
        cpu_read_check(5'h04, 32'h80, "rxd_full_head");

        // Retired instructions, then reset mid-transfer
        for (int i = 0; i < 5; i++) begin
            inst_retire = 1'b1; tick();
            inst_retire = 1'b0; tick();
        end
        cpu_read_check(5'h14, 32'd5, "instret_5");
        cpu_write(5'h08, 32'h77);
        check_eq("tx_pending", {23'd0, tx_valid, tx_data}, 32'h177);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst2_tx_valid", {31'd0, tx_valid}, 32'h0);
        check_eq("rst2_tx_data",  {24'd0, tx_data},  32'h0);
        check_eq("rst2_rx_ready", {31'd0, rx_ready}, 32'h1);
        check_eq("rst2_rdata",    rdata,             32'h0);
        cpu_read_check(5'h14, 32'd0, "instret_after_rst");
        cpu_read_check(5'h00, 32'h1, "ctrl_after_rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
